// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that frames requester bytes (optional source-ID header + data)
// and hands them one at a time to a uart_tx valid/ready input.
module uart_tx_sched #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_SRC    = 4,
    parameter bit          HDR_EN     = 1'b1,
    parameter logic [3:0]  HDR_TAG    = 4'hA
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_SRC-1:0]            req_valid_i,
    output logic [NUM_SRC-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    output logic                          tx_valid_o,
    input  logic                          tx_ready_i,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id_o,
    output logic                          busy_o,
    output logic [15:0]                   frame_cnt_o
);

    localparam int unsigned IdW = $clog2(NUM_SRC);

    typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

    state_e                state_q, state_d;
    logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]        grant_q, grant_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;

    logic [DATA_WIDTH-1:0] req_bytes [NUM_SRC];
    logic                  win_found;
    logic [IdW-1:0]        win_idx;
    logic [IdW:0]          cand_sum;
    logic [IdW-1:0]        cand;
    logic [IdW:0]          grant_inc;
    logic [DATA_WIDTH-1:0] hdr_byte;
    logic                  accept;
    logic                  tx_xfer;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_bytes
        assign req_bytes[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Cyclic search: first valid requester at or after rr_ptr, wrapping at NUM_SRC.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IdW+1)'(k);
            if (cand_sum >= (IdW+1)'(NUM_SRC)) begin
                cand_sum = cand_sum - (IdW+1)'(NUM_SRC);
            end
            cand = cand_sum[IdW-1:0];
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        hdr_byte      = '0;
        hdr_byte[7:0] = {HDR_TAG, 4'(win_idx)};
    end

    assign accept    = win_found && !rst && (state_q == StIdle);
    assign tx_xfer   = tx_valid_q && tx_ready_i;
    assign grant_inc = {1'b0, grant_q} + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            hold_q      <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            hold_q      <= hold_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept)  state_d = HDR_EN ? StHdr : StData;
            StHdr:   if (tx_xfer) state_d = StData;
            StData:  if (tx_xfer) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        hold_d      = hold_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    req_ready_o[win_idx] = 1'b1;
                    hold_d               = req_bytes[win_idx];
                    grant_d              = win_idx;
                    tx_valid_d           = 1'b1;
                    tx_data_d            = HDR_EN ? hdr_byte : req_bytes[win_idx];
                end
            end
            StHdr: begin
                if (tx_xfer) tx_data_d = hold_q;
            end
            StData: begin
                if (tx_xfer) begin
                    tx_valid_d  = 1'b0;
                    tx_data_d   = '0;
                    rr_ptr_d    = (grant_inc == (IdW+1)'(NUM_SRC)) ? '0 : grant_inc[IdW-1:0];
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign grant_id_o  = grant_q;
    assign busy_o      = (state_q != StIdle);
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte width of requester and transmitter data; SHALL be 8 or greater.
REQ-002 Parameter NUM_SRC, default 4, number of requesters; SHALL be 2..16.
REQ-003 Parameter HDR_EN, default 1; 1 = prefix each data byte with a source-ID header byte, 0 = data bytes only.
REQ-004 Parameter HDR_TAG, default 4'hA, upper nibble of the header byte.
REQ-005 clk  input  1  system clock; all logic rising-edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 req_data  input  NUM_SRC*DATA_WIDTH  requester bytes; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_valid  input  NUM_SRC  per-requester byte-available flag.
REQ-009 req_ready  output  NUM_SRC  per-requester accept strobe.
REQ-010 tx_data  output  DATA_WIDTH  byte to uart_tx data_from_sensor.
REQ-011 tx_valid  output  1  to uart_tx valid_from_sensor.
REQ-012 tx_ready  input  1  from uart_tx ready_to_sensor.
REQ-013 grant_id  output  $clog2(NUM_SRC)  ID of the requester currently being served.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 frame_cnt  output  16  count of completed frames (data byte accepted by uart_tx).

Function
REQ-016 Requester transfer SHALL occur on a cycle with req_valid[i] && req_ready[i]; transmitter transfer SHALL occur on a cycle with tx_valid && tx_ready.
REQ-017 FSM states SHALL be IDLE, HDR and DATA.
REQ-018 IDLE: when any req_valid is high, the block SHALL select a winner by round-robin search starting at pointer rr_ptr.
REQ-019 In that IDLE cycle, the block SHALL capture the winner's byte into a holding register, assert only req_ready[winner] for exactly that cycle, and load grant_id.
REQ-020 After the IDLE capture cycle, the next state SHALL be HDR if HDR_EN=1, otherwise DATA.
REQ-021 req_ready SHALL be a combinational function of state, rr_ptr and req_valid, and SHALL be all-zero outside IDLE.
REQ-022 HDR: tx_valid=1 and tx_data={HDR_TAG, zero-padded grant_id}, zero-extended to DATA_WIDTH (NUM_SRC=4, id 2 -> 8'hA2); on a transmitter transfer the next state SHALL be DATA.
REQ-023 DATA: tx_valid=1 and tx_data=held byte; on a transmitter transfer the next state SHALL be IDLE, rr_ptr SHALL become (grant_id+1) mod NUM_SRC, and frame_cnt SHALL increment by 1.
REQ-024 tx_valid and tx_data SHALL be registered outputs.
REQ-025 tx_valid SHALL stay high and tx_data stable from entry to HDR/DATA until the transmitter transfer, whatever tx_ready does.
REQ-026 The first header or data byte SHALL be presented the cycle after the capture; a lone request with tx_ready held high SHALL reach IDLE again 3 cycles after capture with HDR_EN=1, 2 cycles with HDR_EN=0.
REQ-027 Requesters SHALL NOT be accepted while busy; their req_valid is held pending and does not affect the frame in flight.
REQ-028 A requester that drops req_valid after capture SHALL NOT affect transmission of its captured byte.
REQ-029 Simultaneous requests SHALL be served in cyclic order from rr_ptr, so no requester is served twice while another valid requester waits.
REQ-030 frame_cnt SHALL wrap from 16'hFFFF to 16'h0000.
REQ-031 The block SHALL NOT return from HDR or DATA to IDLE except via a transmitter transfer or reset.

Reset
REQ-032 While rst is high, outputs SHALL be: state IDLE, tx_valid 0, tx_data 0, req_ready 0, grant_id 0, busy 0, frame_cnt 0, rr_ptr 0, holding register 0; assertion takes effect without a clock edge.
REQ-033 rst asserted mid-frame SHALL discard the captured byte; tx_valid SHALL fall immediately and the byte SHALL NOT be retransmitted.
REQ-034 Arbitration SHALL restart at requester 0 on the first clock edge after rst deasserts.

Verification
REQ-035 Single request: HDR_EN=1, req_valid[1]=1 with byte 8'hA5, tx_ready stalled 10 cycles per byte -> req_ready[1] pulses once; bytes 8'hA1 then 8'hA5 appear; frame_cnt=1.
REQ-036 All four valid together after reset, bytes C4/B5/9A/3C, tx_ready high -> order 8'hA0,C4,A1,B5,A2,9A,A3,3C; each req_ready pulses once; frame_cnt=4.
REQ-037 Fairness: req_valid[0] held high continuously, req_valid[2] high -> service alternates 0,2,0,2; requester 0 is never served twice in a row.
REQ-038 Backpressure: tx_ready low 50 cycles during DATA -> tx_valid stays 1, tx_data stable, req_ready all 0 throughout.
REQ-039 HDR_EN=0 with tx_ready high -> only data bytes appear, one frame per 2 cycles.
REQ-040 Reset mid-HDR -> tx_valid 0 the same cycle; after release, a new request on requester 3 is served with header 8'hA3.
